// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the TX and RX sides: frame state
// encodings, the default baud divisor for a 100 MHz clock at 115200 baud,
// parity-mode constants and a parity helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      UART_IDLE   = 3'd0,
      UART_START  = 3'd1,
      UART_DATA   = 3'd2,
      UART_PARITY = 3'd3,
      UART_STOP   = 3'd4
   } uart_state_t;

   localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

   localparam bit UART_PARITY_EVEN = 1'b0;
   localparam bit UART_PARITY_ODD  = 1'b1;

   // Parity over a word zero-extended to the widest supported data width;
   // the extra zero bits do not change the XOR.
   function automatic logic uart_parity(input logic [8:0] data, input logic odd);
      logic p;
      p = odd;
      for (int unsigned i = 0; i < 9; i++) begin
         p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Valid/ready word handshake between a byte source and the UART transmitter.
// Signals:
//   tx_valid  source has a word on tx_data
//   tx_data   word to send (DATA_BITS wide, LSB sent first)
//   tx_ready  transmitter can accept a word this cycle
// Modports: master = word source, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
   parameter int unsigned DATA_BITS = 8
) ();

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps at
// each bit boundary.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   clear        synchronous clear of the counter (start of a new frame)
//   enable       count this cycle
//   bit_end      terminal count: last cycle of the current bit
//   bit_pre_end  cycle before the terminal count, for registered look-ahead
// -----------------------------------------------------------------------------
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((CLKS_PER_BIT >= 1) ? CLKS_PER_BIT - 1 : 0);
   localparam logic [CW-1:0] CNT_PRE  = CW'((CLKS_PER_BIT >= 2) ? CLKS_PER_BIT - 2 : 0);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bit_end     = enable && (cnt == CNT_LAST);
   assign bit_pre_end = enable && (cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter: start bit, DATA_BITS data bits (LSB first),
// optional even/odd parity bit, STOP_BITS stop bits. Words enter through a
// valid/ready handshake and are buffered for the duration of the frame.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset; aborts any frame in progress
//   bus      slave side of the word handshake (tx_valid, tx_data, tx_ready)
//   tx_out   registered serial line, idles high
//   tx_busy  registered, high while a frame is in progress
//   tx_done  registered one-cycle pulse in the final stop-bit cycle
// -----------------------------------------------------------------------------
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   uart_tx_param_if.slave  bus,
   output logic            tx_out,
   output logic            tx_busy,
   output logic            tx_done
);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_param: DATA_BITS must be in 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end

   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);
   localparam logic          ODD_SEL   = (PARITY_ODD != 0) ? UART_PARITY_ODD : UART_PARITY_EVEN;

   uart_state_t          state_q, state_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] buf_q;
   logic                 par_q;
   logic                 out_d;
   logic                 done_d;
   logic                 accept;
   logic                 bit_end;
   logic                 bit_pre_end;

   assign bus.tx_ready = (state_q == UART_IDLE);
   assign accept       = bus.tx_valid && (state_q == UART_IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (accept),
      .enable     (state_q != UART_IDLE),
      .bit_end    (bit_end),
      .bit_pre_end(bit_pre_end)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= UART_IDLE;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         buf_q   <= '0;
         par_q   <= 1'b0;
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         if (accept) begin
            buf_q <= bus.tx_data;
            par_q <= uart_parity(9'(bus.tx_data), ODD_SEL);
         end
         tx_out  <= out_d;
         tx_busy <= (state_d != UART_IDLE);
         tx_done <= done_d;
      end
   end

   // Outputs are registered, so the line level and done flag are decoded from
   // the next state; tx_done is set one cycle ahead using bit_pre_end so that
   // the registered pulse lands in the final stop-bit cycle.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      out_d   = 1'b1;

      case (state_q)
         UART_IDLE: begin
            if (accept) begin
               state_d = UART_START;
               bit_d   = '0;
               stop_d  = 1'b0;
            end
         end
         UART_START: begin
            if (bit_end) begin
               state_d = UART_DATA;
            end
         end
         UART_DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? UART_PARITY : UART_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         UART_PARITY: begin
            if (bit_end) begin
               state_d = UART_STOP;
            end
         end
         UART_STOP: begin
            if (bit_pre_end && (stop_q == STOP_LAST)) begin
               done_d = 1'b1;
            end
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  state_d = UART_IDLE;
                  stop_d  = 1'b0;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = UART_IDLE;
         end
      endcase

      case (state_d)
         UART_START:  out_d = 1'b0;
         UART_DATA:   out_d = buf_q[bit_d];
         UART_PARITY: out_d = par_q;
         default:     out_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Self-checking bench for uart_tx_param. Three instances cover 8E1, 8O1 and
// 7N2 framing at 4 clocks per bit. Expected frames are queued when a word is
// offered and compared cycle by cycle against the serial line.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

   localparam int unsigned N = 4;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      string       tag;
   } frame_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   uart_tx_param_if #(.DATA_BITS(8)) if_a ();
   uart_tx_param_if #(.DATA_BITS(8)) if_b ();
   uart_tx_param_if #(.DATA_BITS(7)) if_c ();

   logic out_a, busy_a, done_a;
   logic out_b, busy_b, done_b;
   logic out_c, busy_c, done_c;

   uart_tx_param #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(if_a), .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a));
   uart_tx_param #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(if_b), .tx_out(out_b), .tx_busy(busy_b), .tx_done(done_b));
   uart_tx_param #(.CLKS_PER_BIT(N), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
      .clk(clk), .reset_n(reset_n), .bus(if_c), .tx_out(out_c), .tx_busy(busy_c), .tx_done(done_c));

   frame_t sb[$];
   int total = 0;
   int bad   = 0;

   function automatic logic get_out(input int sel);
      case (sel)
         0:       return out_a;
         1:       return out_b;
         default: return out_c;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic get_done(input int sel);
      case (sel)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   function automatic logic get_ready(input int sel);
      case (sel)
         0:       return if_a.tx_ready;
         1:       return if_b.tx_ready;
         default: return if_c.tx_ready;
      endcase
   endfunction

   task automatic drive(input int sel, input logic v, input logic [8:0] d);
      case (sel)
         0: begin if_a.tx_valid = v; if_a.tx_data = d[7:0]; end
         1: begin if_b.tx_valid = v; if_b.tx_data = d[7:0]; end
         default: begin if_c.tx_valid = v; if_c.tx_data = d[6:0]; end
      endcase
   endtask

   // Reference frame: bit 0 is the start bit, then data LSB first, optional
   // parity, then stop bits.
   function automatic frame_t model(input logic [8:0] d, input int dbits, input bit pen,
                                    input bit podd, input int sbits, input string tag);
      frame_t f;
      int ones;
      f.bits = '0;
      ones = 0;
      for (int i = 0; i < dbits; i++) begin
         f.bits[1 + i] = d[i];
         if (d[i]) ones++;
      end
      f.nbits = 1 + dbits;
      if (pen) begin
         f.bits[f.nbits] = ((ones % 2) == 1) ^ podd;
         f.nbits++;
      end
      for (int i = 0; i < sbits; i++) begin
         f.bits[f.nbits] = 1'b1;
         f.nbits++;
      end
      f.tag = tag;
      return f;
   endfunction

   function automatic frame_t lit(input logic [15:0] bits, input int nbits, input string tag);
      frame_t f;
      f.bits  = bits;
      f.nbits = nbits;
      f.tag   = tag;
      return f;
   endfunction

   task automatic check_idle(input int sel, input string name);
      total++;
      if (get_out(sel) !== 1'b1) begin
         bad++; $display("FAIL %s tx_out: got %b want 1", name, get_out(sel));
      end
      total++;
      if (get_busy(sel) !== 1'b0) begin
         bad++; $display("FAIL %s tx_busy: got %b want 0", name, get_busy(sel));
      end
      total++;
      if (get_done(sel) !== 1'b0) begin
         bad++; $display("FAIL %s tx_done: got %b want 0", name, get_done(sel));
      end
      total++;
      if (get_ready(sel) !== 1'b1) begin
         bad++; $display("FAIL %s tx_ready: got %b want 1", name, get_ready(sel));
      end
   endtask

   // Called at a negedge with tx_valid already driven on an idle DUT. Waits
   // the acceptance edge, then checks every frame cycle against the queued
   // expectation and finishes at the negedge of the idle cycle that follows.
   task automatic run_frame(input int sel, input logic keep_valid, input logic [8:0] next_data);
      frame_t f;
      int cyc;
      int line_err, busy_err, done_err;
      logic want_line, want_done;
      logic got_line, got_busy, got_done;
      line_err = -1; busy_err = -1; done_err = -1;
      got_line = 1'b0; got_busy = 1'b0; got_done = 1'b0;
      want_line = 1'b0; want_done = 1'b0;

      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL scoreboard: got empty queue want a frame");
         return;
      end
      f = sb.pop_front();

      @(posedge clk);
      @(negedge clk);
      drive(sel, keep_valid, next_data);
      cyc = f.nbits * N;
      for (int c = 0; c < cyc; c++) begin
         if (c > 0) @(negedge clk);
         want_line = f.bits[c / N];
         want_done = (c == cyc - 1);
         if (get_out(sel) !== want_line && line_err < 0) begin
            line_err = c; got_line = get_out(sel);
         end
         if (get_busy(sel) !== 1'b1 && busy_err < 0) begin
            busy_err = c; got_busy = get_busy(sel);
         end
         if (get_done(sel) !== want_done && done_err < 0) begin
            done_err = c; got_done = get_done(sel);
         end
      end
      if (line_err >= 0) begin
         bad++;
         $display("FAIL %s line: cycle %0d got %b want %b", f.tag, line_err, got_line,
                  f.bits[line_err / N]);
      end
      total++;
      if (busy_err >= 0) begin
         bad++; $display("FAIL %s busy: cycle %0d got %b want 1", f.tag, busy_err, got_busy);
      end
      total++;
      if (done_err >= 0) begin
         bad++;
         $display("FAIL %s done: cycle %0d got %b want %b", f.tag, done_err, got_done,
                  (done_err == cyc - 1));
      end
      @(negedge clk);
      check_idle(sel, {f.tag, "_gap"});
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(0, 1'b0, 9'h000);
      drive(1, 1'b0, 9'h000);
      drive(2, 1'b0, 9'h000);
      repeat (5) begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) check_idle(s, "reset");
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) check_idle(s, "post_reset");
      end
   endtask

   task automatic test_8e1();
      sb.push_back(lit(16'h04AA, 11, "8e1_55"));
      drive(0, 1'b1, 9'h055);
      run_frame(0, 1'b0, 9'h000);
   endtask

   task automatic test_parity();
      sb.push_back(lit(16'h040E, 11, "odd_07"));
      drive(1, 1'b1, 9'h007);
      run_frame(1, 1'b0, 9'h000);
      sb.push_back(lit(16'h060E, 11, "even_07"));
      drive(0, 1'b1, 9'h007);
      run_frame(0, 1'b0, 9'h000);
   endtask

   task automatic test_back_to_back();
      sb.push_back(model(9'h0A5, 8, 1'b1, 1'b0, 1, "b2b_A5"));
      sb.push_back(model(9'h03C, 8, 1'b1, 1'b0, 1, "b2b_3C"));
      drive(0, 1'b1, 9'h0A5);
      run_frame(0, 1'b1, 9'h03C);
      run_frame(0, 1'b0, 9'h0FF);
      @(negedge clk);
      check_idle(0, "b2b_after");
   endtask

   task automatic test_7n2();
      sb.push_back(lit(16'h0382, 10, "7n2_41"));
      drive(2, 1'b1, 9'h041);
      run_frame(2, 1'b0, 9'h000);
   endtask

   task automatic test_reset_mid_frame();
      drive(0, 1'b1, 9'h0F0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 9'h000);
      repeat (17) @(negedge clk);
      total++;
      if (out_a !== 1'b0) begin
         bad++; $display("FAIL abort_pre: tx_out got %b want 0", out_a);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (out_a !== 1'b1) begin
         bad++; $display("FAIL abort_async: tx_out got %b want 1", out_a);
      end
      total++;
      if (busy_a !== 1'b0) begin
         bad++; $display("FAIL abort_async: tx_busy got %b want 0", busy_a);
      end
      repeat (3) begin
         @(negedge clk);
         check_idle(0, "abort_hold");
      end
      reset_n = 1'b1;
      @(negedge clk);
      check_idle(0, "abort_release");
      sb.push_back(model(9'h00F, 8, 1'b1, 1'b0, 1, "after_abort_0F"));
      drive(0, 1'b1, 9'h00F);
      run_frame(0, 1'b0, 9'h000);
   endtask

   initial begin
      test_reset();
      test_8e1();
      test_parity();
      test_back_to_back();
      test_7n2();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
